// File: rtl/output_port_arbiter_pkg.sv
// Shared types and helpers for the leaf egress arbiter: packet geometry, FSM encodings, clog2.
package output_port_arbiter_pkg;

  localparam int PKT_BITS  = 97;
  localparam int VALID_BIT = PKT_BITS - 1;

  typedef logic [0:0] arb_state_t;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Egress bundle between the Output_Port array, the arbiter and the BFT switch.
interface output_port_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int PACKET_BITS = output_port_arbiter_pkg::PKT_BITS
);
  localparam int PW = (NUM_PORTS > 1) ? output_port_arbiter_pkg::clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]             empty_vec;
  logic [NUM_PORTS*PACKET_BITS-1:0] internal_out_vec;
  logic [NUM_PORTS-1:0]             rd_en_sel_vec;
  logic [PACKET_BITS-1:0]           dout_leaf2bft;
  logic                             out_ready;
  logic [PW-1:0]                    grant_port;

  modport master (
    input  empty_vec, internal_out_vec, out_ready,
    output rd_en_sel_vec, dout_leaf2bft, grant_port
  );

  modport slave (
    output empty_vec, internal_out_vec, out_ready,
    input  rd_en_sel_vec, dout_leaf2bft, grant_port
  );
endinterface

// File: rtl/output_port_arbiter_fifo.sv
// Register-based sync FIFO; head is combinational from the read pointer, zero when empty.
// Simultaneous push/pop keeps the count and advances both pointers.
module output_port_arbiter_fifo import output_port_arbiter_pkg::*; #(
  parameter int WIDTH = PKT_BITS,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_dat,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic [clog2(DEPTH):0] o_count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin, burst-limited read grants over NUM_PORTS Output_Ports; captures packets one cycle
// after grant into a small FIFO presented to the BFT, stalling grants when FIFO+in-flight is full.
module output_port_arbiter import output_port_arbiter_pkg::*; #(
  parameter int NUM_PORTS      = 4,
  parameter int PACKET_BITS    = PKT_BITS,
  parameter int MAX_BURST      = 8,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  output_port_arbiter_if.master bus
);
  localparam int PW = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int CW = clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  arb_state_t             r_state;
  logic [PW-1:0]          r_cur;
  logic [PW-1:0]          r_rr_ptr;
  logic [PW-1:0]          r_sel_d;
  logic [BW-1:0]          r_burst_cnt;
  logic                   r_inflight;
  logic [CW-1:0]          w_fifo_count;
  logic                   w_space_ok;
  logic                   w_found;
  logic [PW-1:0]          w_pick;
  logic [PW-1:0]          w_next_ptr;
  logic                   w_cur_rdy;
  logic                   w_grant;
  logic                   w_last_grant;
  logic                   w_push;
  logic [PACKET_BITS-1:0] w_cap;

  // The in-flight grant reserves a slot so the FIFO never overflows.
  assign w_space_ok = (w_fifo_count + CW'(r_inflight)) < CW'(OUT_FIFO_DEPTH);
  assign w_next_ptr = (r_cur == LAST_PORT) ? '0 : r_cur + 1'b1;
  assign w_cur_rdy  = !bus.empty_vec[r_cur];
  assign w_grant    = (r_state == S_BURST) && w_cur_rdy && w_space_ok && (r_burst_cnt < BURST_MAX);
  assign w_last_grant = w_grant && (r_burst_cnt == BURST_MAX - 1'b1);

  // Descending scan so the nearest port at or above rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!bus.empty_vec[idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    bus.rd_en_sel_vec = '0;
    if (w_grant) bus.rd_en_sel_vec[r_cur] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_sel_d     <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_sel_d    <= r_cur;
      r_inflight <= w_grant;
      case (r_state)
        S_IDLE: begin
          if (w_found && w_space_ok) begin
            r_cur       <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_grant) r_burst_cnt <= r_burst_cnt + 1'b1;
          // Leaving on the last grant keeps the rotation cost to a single IDLE bubble.
          if (!w_cur_rdy || (r_burst_cnt == BURST_MAX) || w_last_grant) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cap  = bus.internal_out_vec[int'(r_sel_d) * PACKET_BITS +: PACKET_BITS];
  assign w_push = r_inflight && w_cap[PACKET_BITS-1];

  output_port_arbiter_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_cap),
    .i_pop      (bus.out_ready),
    .o_head     (bus.dout_leaf2bft),
    .o_count    (w_fifo_count)
  );

  assign bus.grant_port = r_cur;

endmodule
